code_lock_fsm: RTL
==================

// Module: code_lock_fsm
// PURPOSE
//  Parametrised keypad combination-lock controller. It is the successor of the fixed 3-bit-state lock.
//  Accepts a stream of digits and compares it against a programmable CODE_LEN-digit code.
//  Drives unlocked / closer, with these additions:
//    - failed-attempt lockout
//    - inter-digit timeout
//    - timed unlock window
//    - code re-programming while unlocked
//  Sits between the keypad debouncer/encoder and the actuator driver.
// PARAMETERS
//  CODE_LEN    4        digits per code (2..8)
//  DIGIT_W     4        bits per digit
//  RESET_CODE  16'h1234 code loaded at reset (CODE_LEN*DIGIT_W bits; digit 0 in LSBs)
//  MAX_FAIL    3        consecutive failed entries before lockout (>=1)
//  LOCKOUT_CYC 16       lockout duration, cycles
//  UNLOCK_CYC  8        unlock window, cycles
//  ENTRY_TO    32       max idle cycles between digits during an entry
// PORTS
//  clk         in  1                 clock, rising edge
//  rst_n       in  1                 asynchronous reset, active low
//  digit_valid in  1                 one-cycle strobe: digit is valid
//  digit       in  DIGIT_W           keypad digit
//  lock_req    in  1                 relock immediately (honoured in UNLOCK only)
//  code_load   in  1                 latch code_in as new code (honoured in UNLOCK only)
//  code_in     in  CODE_LEN*DIGIT_W  new code, digit 0 in LSBs
//  unlocked    out 1                 high for the whole UNLOCK state
//  closer      out 1                 1-cycle pulse: accepted digit matched, all prior digits of this entry matched
//  locked_out  out 1                 high for the whole LOCKOUT state
//  fail_cnt    out clog2(MAX_FAIL+1) consecutive failures so far
// BEHAVIOUR
//  Reset (async, rst_n=0):
//    - state=IDLE, idx=0, mismatch=0, timer=0, code_reg=RESET_CODE.
//    - unlocked=0, closer=0, locked_out=0, fail_cnt=0.
//  All outputs are registered. closer/unlocked/locked_out change 1 cycle after the causing edge.
//  States:
//    IDLE    digit_valid: compare against digit 0, idx<=1, -> ENTRY (CODE_LEN=1 impossible; min 2).
//    ENTRY   digit_valid: compare digit against code_reg[idx]; mismatch|=neq; idx++; timer reloads ENTRY_TO.
//            On the CODE_LEN-th digit, evaluate (see Attempt evaluation) -> UNLOCK, IDLE or LOCKOUT.
//            Timer expires with no digit: -> IDLE, idx=0; NOT counted as a failure.
//    UNLOCK  Timer loaded with UNLOCK_CYC on entry.
//            Exits to IDLE when the timer expires OR lock_req=1.
//            code_load=1: code_reg<=code_in next edge; stays UNLOCK; timer not reloaded.
//            digit_valid ignored.
//    LOCKOUT Timer loaded with LOCKOUT_CYC on entry; digit_valid ignored.
//            Timer expiry: -> IDLE, fail_cnt<=0.
//  Attempt evaluation (on the CODE_LEN-th digit):
//    - all matched: -> UNLOCK, fail_cnt<=0.
//    - else, fail_cnt+1 < MAX_FAIL: -> IDLE, fail_cnt++.
//    - else (fail_cnt+1 == MAX_FAIL): -> LOCKOUT, fail_cnt<=MAX_FAIL.
//  Entry rules:
//    - Wrong digit does not abort the entry; all CODE_LEN digits are consumed before a verdict.
//    - No overlapping/sliding match.
//  closer pulses only while mismatch is still 0 (including this digit); never in UNLOCK or LOCKOUT.
//  code_load outside UNLOCK is ignored. code_in is sampled only on the load edge.
//  Simultaneous events:
//    - lock_req & code_load in UNLOCK: the load happens AND the FSM relocks.
//    - Timer expiry & digit_valid on the same edge in ENTRY: the digit wins.
//  Timer: single down-counter; "expires" = reaches 1 while in the timed state (exact cycle counts).
//  Mid-operation reset:
//    - Immediately returns to the reset state.
//    - Reprogrammed code is lost (RESET_CODE restored).
//    - fail_cnt cleared.
// STRUCTURE
//  lock_pkg.vh:
//    - state encodings S_IDLE=2'd0, S_ENTRY=2'd1, S_UNLOCK=2'd2, S_LOCKOUT=2'd3.
//    - clog2 function.
//  Keeps the three-part split: next-state logic, state register, output logic, all in this file.
//  Sub-module lock_timer (load value, load strobe, expire flag) is shared by all three timed uses.
// TESTING (defaults, code 1,2,3,4 = 16'h4321 LSB-first digits... RESET_CODE 16'h1234 => digit0=4,1=3,2=2,3=1)
//  1. Reset, enter 4,3,2,1 -> closer pulses x4, unlocked=1 for exactly 8 cycles, then IDLE.
//  2. Enter 4,9,2,1 -> closer on digit 1 only, no unlock, fail_cnt=1; idx back to 0.
//  3. Three wrong entries -> locked_out=1 for 16 cycles, digits ignored; then fail_cnt=0.
//  4. Unlock, code_load with code_in=16'h5678, lock_req -> unlocked drops next cycle.
//     Enter 8,7,6,5 -> unlocks; old code fails.
//  5. Enter 4,3 then 33 idle cycles -> back to IDLE, fail_cnt unchanged; digit on expiry edge is accepted.
//  6. rst_n low mid-ENTRY and in LOCKOUT -> all outputs 0 immediately; RESET_CODE restored.

Source files
------------

// File: rtl/code_lock_fsm_pkg.sv
// Shared definitions for the keypad combination lock: state encoding and a
// ceiling-log2 helper used to size counters and ports.
package code_lock_fsm_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTRY   = 2'd1,
        S_UNLOCK  = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    // Returns at least 1 so that a value of 1 or 2 still yields a usable width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/code_lock_fsm_timer.sv
// Loadable down-counter shared by the entry timeout, the unlock window and
// the lockout period; it flags expiry on the last counted cycle.
module code_lock_fsm_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/code_lock_fsm.sv
// Parametrised keypad combination-lock controller with failed-attempt
// lockout, inter-digit timeout, timed unlock window and code reprogramming.
module code_lock_fsm
    import code_lock_fsm_pkg::*;
#(
    parameter int                          CODE_LEN    = 4,
    parameter int                          DIGIT_W     = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE  = 16'h1234,
    parameter int                          MAX_FAIL    = 3,
    parameter int                          LOCKOUT_CYC = 16,
    parameter int                          UNLOCK_CYC  = 8,
    parameter int                          ENTRY_TO    = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           digit_valid,
    input  logic [DIGIT_W-1:0]             digit,
    input  logic                           lock_req,
    input  logic                           code_load,
    input  logic [CODE_LEN*DIGIT_W-1:0]    code_in,
    output logic                           unlocked,
    output logic                           closer,
    output logic                           locked_out,
    output logic [clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int IDX_W   = clog2(CODE_LEN);
    localparam int FAIL_W  = clog2(MAX_FAIL + 1);
    localparam int T_MAX_A = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int T_MAX   = (T_MAX_A > ENTRY_TO) ? T_MAX_A : ENTRY_TO;
    localparam int TIMER_W = clog2(T_MAX + 1);

    state_t                        state, next_state;
    logic [IDX_W-1:0]              idx, idx_n;
    logic                          mismatch, mismatch_n;
    logic [CODE_LEN*DIGIT_W-1:0]   code_reg, code_reg_n;
    logic [FAIL_W-1:0]             fail_n;
    logic                          closer_n;
    logic                          timer_load;
    logic [TIMER_W-1:0]            timer_val;
    logic                          timer_expire;
    logic [DIGIT_W-1:0]            code_digit;
    logic                          neq;
    logic                          last_digit;

    code_lock_fsm_timer #(.W(TIMER_W)) lock_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    always_comb begin
        code_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx == IDX_W'(i)) begin
                code_digit = code_reg[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign neq        = (digit != code_digit);
    assign last_digit = (idx == IDX_W'(CODE_LEN - 1));

    // Next-state logic; idx is always 0 in IDLE, so the IDLE compare hits digit 0.
    always_comb begin
        next_state = state;
        idx_n      = idx;
        mismatch_n = mismatch;
        code_reg_n = code_reg;
        fail_n     = fail_cnt;
        closer_n   = 1'b0;
        timer_load = 1'b0;
        timer_val  = TIMER_W'(ENTRY_TO);

        case (state)
            S_IDLE: begin
                if (digit_valid) begin
                    idx_n      = IDX_W'(1);
                    mismatch_n = neq;
                    closer_n   = !neq;
                    timer_load = 1'b1;
                    next_state = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (digit_valid) begin
                    closer_n   = !mismatch && !neq;
                    timer_load = 1'b1;
                    if (last_digit) begin
                        idx_n      = '0;
                        mismatch_n = 1'b0;
                        if (!(mismatch || neq)) begin
                            next_state = S_UNLOCK;
                            fail_n     = '0;
                            timer_val  = TIMER_W'(UNLOCK_CYC);
                        end else if ((int'(fail_cnt) + 1) < MAX_FAIL) begin
                            next_state = S_IDLE;
                            fail_n     = fail_cnt + FAIL_W'(1);
                        end else begin
                            next_state = S_LOCKOUT;
                            fail_n     = FAIL_W'(MAX_FAIL);
                            timer_val  = TIMER_W'(LOCKOUT_CYC);
                        end
                    end else begin
                        idx_n      = idx + IDX_W'(1);
                        mismatch_n = mismatch | neq;
                    end
                end else if (timer_expire) begin
                    next_state = S_IDLE;
                    idx_n      = '0;
                    mismatch_n = 1'b0;
                end
            end
            S_UNLOCK: begin
                if (code_load) begin
                    code_reg_n = code_in;
                end
                if (timer_expire || lock_req) begin
                    next_state = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (timer_expire) begin
                    next_state = S_IDLE;
                    fail_n     = '0;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register plus registered outputs, which track the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            mismatch   <= 1'b0;
            code_reg   <= RESET_CODE;
            fail_cnt   <= '0;
            closer     <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= next_state;
            idx        <= idx_n;
            mismatch   <= mismatch_n;
            code_reg   <= code_reg_n;
            fail_cnt   <= fail_n;
            closer     <= closer_n;
            unlocked   <= (next_state == S_UNLOCK);
            locked_out <= (next_state == S_LOCKOUT);
        end
    end

endmodule
